ready_handshake: RTL and testbench

Two-player confirm handshake for the two-board game. It debounces the local confirm button and synchronises the opponent's ready line from the inter-board cable, then emits a single-cycle `commit` once both players are ready. It sits directly upstream of the game top and replaces the raw "local AND opponent" button term that enables the ship/attack registers. The block exchanges a level-signalled `ready_out` with the identical block on the opponent's board.

---
 rtl/ready_pkg.sv | 17 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/ready_handshake.sv | 124 ++++++++++++
 tb/tb_ready_handshake.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ready_pkg.sv
// Shared types for the two-board confirm handshake: FSM state encoding and
// the width helper used to size the saturating counters.
package ready_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT,
        RELEASE
    } state_t;

    // Smallest width that holds every value 0..n.
    function automatic int cnt_w(input longint unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for the local
// confirm button; deb_local only moves after DEBOUNCE_CYCLES differing samples.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_local,
    output logic deb_local
);
    import ready_pkg::*;

    localparam int CNT_W = cnt_w(longint'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_local;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Flip on the last of a run of differing samples; the counter never passes CNT_LAST.
        if (sync2_q != deb_q) begin
            if (cnt_q >= CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_local = deb_q;

endmodule

// File: rtl/ready_handshake.sv
// Two-player confirm handshake: emits a one-cycle commit once both boards are ready.
// Optional ARMED abandonment is built when READY_TIMEOUT_EN is defined.
module ready_handshake #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_local,
    input  logic btn_opp,
    output logic ready_out,
    output logic commit,
    output logic waiting,
    output logic timeout
);
    import ready_pkg::*;

    logic   deb_local;
    logic   deb_prev_q, deb_prev_d;
    logic   opp_sync1_q, opp_sync1_d;
    logic   opp_s_q, opp_s_d;
    state_t state_q, state_d;
    logic   ready_q, ready_d;
    logic   commit_q, commit_d;
    logic   waiting_q, waiting_d;
    logic   timeout_q, timeout_d;
    logic   tmo_hit;
    logic   tmo_fire;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .clr       (clr),
        .btn_local (btn_local),
        .deb_local (deb_local)
    );

`ifdef READY_TIMEOUT_EN
    localparam int TMO_W = cnt_w(longint'(TIMEOUT_CYCLES));
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q >= TMO_LAST);

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ARMED && state_d == ARMED) begin
            tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        opp_sync1_d = btn_opp;
        opp_s_d     = opp_sync1_q;
        deb_prev_d  = deb_local;
        state_d     = state_q;
        tmo_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_local && !deb_prev_q) state_d = ARMED;
            end
            // Opponent readiness takes priority over an expiry in the same cycle.
            ARMED: begin
                if (opp_s_q) begin
                    state_d = COMMIT;
                end else if (tmo_hit) begin
                    state_d  = IDLE;
                    tmo_fire = 1'b1;
                end
            end
            COMMIT: state_d = RELEASE;
            RELEASE: begin
                if (!deb_local && !opp_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d   = (state_d == ARMED) || (state_d == COMMIT);
        commit_d  = (state_d == COMMIT);
        waiting_d = (state_d == ARMED);
        timeout_d = tmo_fire;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            opp_sync1_q <= 1'b0;
            opp_s_q     <= 1'b0;
            deb_prev_q  <= 1'b0;
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            commit_q    <= 1'b0;
            waiting_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            opp_sync1_q <= opp_sync1_d;
            opp_s_q     <= opp_s_d;
            deb_prev_q  <= deb_prev_d;
            state_q     <= state_d;
            ready_q     <= ready_d;
            commit_q    <= commit_d;
            waiting_q   <= waiting_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ready_out = ready_q;
    assign commit    = commit_q;
    assign waiting   = waiting_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_ready_handshake.sv
// Bench for ready_handshake: a single DUT driven from a piecewise stimulus table
// with per-edge expected outputs, plus a cross-connected pair for simultaneous presses.
module tb_ready_handshake;

    localparam int D         = 4;
    localparam int T         = 20;
    localparam int LAST_EDGE = 240;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr, btn_local, btn_opp, btn_pair;
    logic ready_out, commit, waiting, timeout;
    logic ro_a, cm_a, wt_a, to_a;
    logic ro_b, cm_b, wt_b, to_b;

    ready_handshake #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .clr(clr), .btn_local(btn_local), .btn_opp(btn_opp),
        .ready_out(ready_out), .commit(commit), .waiting(waiting), .timeout(timeout)
    );

    ready_handshake #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) u_a (
        .clk(clk), .clr(clr), .btn_local(btn_pair), .btn_opp(ro_b),
        .ready_out(ro_a), .commit(cm_a), .waiting(wt_a), .timeout(to_a)
    );

    ready_handshake #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) u_b (
        .clk(clk), .clr(clr), .btn_local(btn_pair), .btn_opp(ro_a),
        .ready_out(ro_b), .commit(cm_b), .waiting(wt_b), .timeout(to_b)
    );

    // Inputs applied just after edge_n; they hold until the next entry.
    typedef struct {
        int   edge_n;
        logic clr;
        logic bl;
        logic bo;
    } stim_t;

    // Output levels {ready_out, commit, waiting, timeout} from edge_n onward.
    typedef struct {
        int         edge_n;
        logic [3:0] outs;
    } exp_t;

    stim_t      stim[$];
    exp_t       expt[$];
    logic [3:0] sb_q[$];
    int         sb_e[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic add_stim(input int e, input logic c, input logic b, input logic o);
        stim_t s;
        s.edge_n = e; s.clr = c; s.bl = b; s.bo = o;
        stim.push_back(s);
    endtask

    task automatic add_exp(input int e, input logic [3:0] o);
        exp_t x;
        x.edge_n = e; x.outs = o;
        expt.push_back(x);
    endtask

    initial begin
        int         si;
        int         ei;
        int         main_commits;
        int         ca;
        int         cb;
        logic [3:0] cur_exp;
        logic [3:0] req;
        int         req_e;

        // Bounce, handshake, held button, re-press, mid-ARMED reset, held after reset.
        add_stim(0,   1'b0, 1'b1, 1'b0);
        add_stim(2,   1'b0, 1'b0, 1'b0);
        add_stim(4,   1'b0, 1'b1, 1'b0);
        add_stim(6,   1'b0, 1'b0, 1'b0);
        add_stim(8,   1'b0, 1'b1, 1'b0);
        add_stim(30,  1'b0, 1'b1, 1'b1);
        add_stim(40,  1'b0, 1'b1, 1'b0);
        add_stim(60,  1'b0, 1'b0, 1'b0);
        add_stim(75,  1'b0, 1'b1, 1'b0);
        add_stim(90,  1'b0, 1'b1, 1'b1);
        add_stim(100, 1'b0, 1'b0, 1'b0);
        add_stim(110, 1'b0, 1'b1, 1'b0);
        add_stim(120, 1'b1, 1'b1, 1'b0);
        add_stim(121, 1'b0, 1'b1, 1'b0);

        add_exp(0,   4'b0000);
        add_exp(15,  4'b1010);
        add_exp(33,  4'b1100);
        add_exp(34,  4'b0000);
        add_exp(82,  4'b1010);
        add_exp(93,  4'b1100);
        add_exp(94,  4'b0000);
        add_exp(117, 4'b1010);
        add_exp(121, 4'b0000);
        add_exp(128, 4'b1010);
`ifdef READY_TIMEOUT_EN
        add_exp(148, 4'b0001);
        add_exp(149, 4'b0000);
`endif

        // Reset with every input active: clr must dominate.
        clr       = 1'b1;
        btn_local = 1'b1;
        btn_opp   = 1'b1;
        btn_pair  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset dut", {4'b0, ready_out, commit, waiting, timeout}, 8'h00);
            check("reset pair", {ro_a, cm_a, wt_a, to_a, ro_b, cm_b, wt_b, to_b}, 8'h00);
        end
        btn_pair = 1'b0;

        si           = 0;
        ei           = 0;
        main_commits = 0;
        cur_exp      = 4'b0000;
        for (int k = 0; k <= LAST_EDGE; k++) begin
            while (ei < expt.size() && expt[ei].edge_n <= k) begin
                cur_exp = expt[ei].outs;
                ei++;
            end
            sb_q.push_back(cur_exp);
            sb_e.push_back(k);
            @(posedge clk); #1;
            req   = sb_q.pop_front();
            req_e = sb_e.pop_front();
            check($sformatf("edge %0d outs", req_e), {4'b0, ready_out, commit, waiting, timeout}, {4'b0, req});
            main_commits = main_commits + int'(commit);
            while (si < stim.size() && stim[si].edge_n <= k) begin
                clr       = stim[si].clr;
                btn_local = stim[si].bl;
                btn_opp   = stim[si].bo;
                si++;
            end
        end
        check("main commit count", 8'(main_commits), 8'd2);
`ifndef READY_TIMEOUT_EN
        check("still armed at 100 cycles", {7'b0, waiting}, 8'h01);
`endif

        btn_local = 1'b0;
        btn_opp   = 1'b0;

        // Cross-connected pair, both buttons pressed after the same edge.
        ca = 0;
        cb = 0;
        btn_pair = 1'b1;
        for (int r = 1; r <= 20; r++) begin
            @(posedge clk); #1;
            ca = ca + int'(cm_a);
            cb = cb + int'(cm_b);
            if (r == 6)  check("pair not yet ready", {6'b0, ro_a, ro_b}, 8'h00);
            if (r == 7)  check("pair armed", {4'b0, ro_a, ro_b, wt_a, wt_b}, 8'h0f);
            if (r == 10) check("pair commit", {6'b0, cm_a, cm_b}, 8'h03);
            if (r == 11) check("pair ready drop", {4'b0, ro_a, ro_b, cm_a, cm_b}, 8'h00);
        end
        check("pair a commits", 8'(ca), 8'd1);
        check("pair b commits", 8'(cb), 8'd1);

        btn_pair = 1'b0;
        for (int r = 21; r <= 40; r++) begin
            @(posedge clk); #1;
            ca = ca + int'(cm_a);
            cb = cb + int'(cm_b);
        end
        check("pair idle outs", {ro_a, cm_a, wt_a, to_a, ro_b, cm_b, wt_b, to_b}, 8'h00);

        btn_pair = 1'b1;
        for (int r = 41; r <= 60; r++) begin
            @(posedge clk); #1;
            ca = ca + int'(cm_a);
            cb = cb + int'(cm_b);
            if (r == 50) check("pair second commit", {6'b0, cm_a, cm_b}, 8'h03);
        end
        check("pair a total commits", 8'(ca), 8'd2);
        check("pair b total commits", 8'(cb), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
